// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic MAC array sequencer.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FEED  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int N_DEF    = 2;
    localparam int KMAX_DEF = 8;
    localparam int DW_DEF   = 8;

    // Lane `lane` carries inner index t-lane during step t; valid only inside [0, kl).
    function automatic logic skew_hit(input int t, input int lane, input int kl);
        return (t >= lane) && ((t - lane) < kl);
    endfunction

endpackage

// File: rtl/systolic_opbuf.sv
// N x KMAX operand register file: one write port, N combinational read ports
// (one per array lane). Contents are intentionally not reset.
module systolic_opbuf
    import systolic_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int KMAX = KMAX_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = $clog2(N * KMAX)
) (
    input  logic            clk,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [DW-1:0]   wr_data_i,
    input  logic [N*AW-1:0] rd_addr_i,
    output logic [N*DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [N*KMAX];

    // Storage write port
    always_ff @(posedge clk) begin
        if (wr_en_i && (int'(wr_addr_i) < N * KMAX)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Per-lane read ports
    always_comb begin
        rd_data_o = '0;
        for (int n = 0; n < N; n++) begin
            rd_data_o[n*DW +: DW] = mem_q[rd_addr_i[n*AW +: AW]];
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic MAC array: clears the PEs,
// then streams skewed operands. Build macro SYSTOLIC_ACC_EN enables acc (skip CLEAR).
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int KMAX = KMAX_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = $clog2(N * KMAX)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_wr_en,
    input  logic [AW-1:0]              a_wr_addr,
    input  logic [DW-1:0]              a_wr_data,
    input  logic                       b_wr_en,
    input  logic [AW-1:0]              b_wr_addr,
    input  logic [DW-1:0]              b_wr_data,
    input  logic                       start,
    input  logic [$clog2(KMAX+1)-1:0]  k_len,
    input  logic                       acc,
    output logic [N*DW-1:0]            a_edge,
    output logic [N*DW-1:0]            b_edge,
    output logic                       pe_clr,
    output logic                       busy,
    output logic                       done
);

    localparam int KLW = $clog2(KMAX + 1);
    localparam int TW  = $clog2(KMAX + 2 * N);

    state_e           state_q;
    logic [TW-1:0]    t_q;
    logic [KLW-1:0]   kl_q;
    logic [N*DW-1:0]  a_edge_q;
    logic [N*DW-1:0]  b_edge_q;
    logic             pe_clr_q;
    logic             busy_q;
    logic             done_q;

    logic [KLW-1:0]   kl_in_s;
    int               step_t_s;
    int               step_kl_s;
    logic [N-1:0]     hit_s;
    logic [N*AW-1:0]  rd_addr_s;
    logic [N*DW-1:0]  a_rd_s;
    logic [N*DW-1:0]  b_rd_s;
    logic [N*DW-1:0]  a_step_s;
    logic [N*DW-1:0]  b_step_s;
    logic             feed_last_s;

`ifndef SYSTOLIC_ACC_EN
    logic             acc_unused_s;
    assign acc_unused_s = acc;
`endif

    // A and B share a lane*KMAX + k layout, so one read address serves both.
    systolic_opbuf #(.N(N), .KMAX(KMAX), .DW(DW), .AW(AW)) u_abuf (
        .clk       (clk),
        .wr_en_i   (a_wr_en),
        .wr_addr_i (a_wr_addr),
        .wr_data_i (a_wr_data),
        .rd_addr_i (rd_addr_s),
        .rd_data_o (a_rd_s)
    );

    systolic_opbuf #(.N(N), .KMAX(KMAX), .DW(DW), .AW(AW)) u_bbuf (
        .clk       (clk),
        .wr_en_i   (b_wr_en),
        .wr_addr_i (b_wr_addr),
        .wr_data_i (b_wr_data),
        .rd_addr_i (rd_addr_s),
        .rd_data_o (b_rd_s)
    );

    // Operands for the step about to be registered onto the edges
    always_comb begin
        kl_in_s   = (int'(k_len) > KMAX) ? KLW'(KMAX) : k_len;
        step_t_s  = 0;
        step_kl_s = int'(kl_q);
        case (state_q)
            IDLE:    step_kl_s = int'(kl_in_s);
            FEED:    step_t_s  = int'(t_q) + 1;
            default: step_t_s  = 0;
        endcase
        hit_s     = '0;
        rd_addr_s = '0;
        a_step_s  = '0;
        b_step_s  = '0;
        for (int lane = 0; lane < N; lane++) begin
            hit_s[lane] = skew_hit(step_t_s, lane, step_kl_s);
            if (hit_s[lane]) begin
                rd_addr_s[lane*AW +: AW] = AW'(lane * KMAX + step_t_s - lane);
                a_step_s[lane*DW +: DW]  = a_rd_s[lane*DW +: DW];
                b_step_s[lane*DW +: DW]  = b_rd_s[lane*DW +: DW];
            end else begin
                rd_addr_s[lane*AW +: AW] = '0;
                a_step_s[lane*DW +: DW]  = '0;
                b_step_s[lane*DW +: DW]  = '0;
            end
        end
        feed_last_s = (int'(t_q) == (int'(kl_q) + 2 * N - 3));
    end

    // Tile sequencing FSM with registered edge, clear, busy and done outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            t_q      <= '0;
            kl_q     <= '0;
            a_edge_q <= '0;
            b_edge_q <= '0;
            pe_clr_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    a_edge_q <= '0;
                    b_edge_q <= '0;
                    pe_clr_q <= 1'b0;
                    done_q   <= 1'b0;
                    t_q      <= '0;
                    if (start) begin
                        kl_q   <= kl_in_s;
                        busy_q <= 1'b1;
`ifdef SYSTOLIC_ACC_EN
                        if (acc && (kl_in_s != KLW'(0))) begin
                            state_q  <= FEED;
                            a_edge_q <= a_step_s;
                            b_edge_q <= b_step_s;
                        end else if (acc) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= CLEAR;
                            pe_clr_q <= 1'b1;
                        end
`else
                        state_q  <= CLEAR;
                        pe_clr_q <= 1'b1;
`endif
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    pe_clr_q <= 1'b0;
                    t_q      <= '0;
                    if (kl_q != KLW'(0)) begin
                        state_q  <= FEED;
                        a_edge_q <= a_step_s;
                        b_edge_q <= b_step_s;
                    end else begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        a_edge_q <= '0;
                        b_edge_q <= '0;
                    end
                end
                FEED: begin
                    if (feed_last_s) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        t_q      <= '0;
                        a_edge_q <= '0;
                        b_edge_q <= '0;
                    end else begin
                        t_q      <= t_q + TW'(1);
                        a_edge_q <= a_step_s;
                        b_edge_q <= b_step_s;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    a_edge_q <= '0;
                    b_edge_q <= '0;
                end
                default: begin
                    state_q  <= IDLE;
                    t_q      <= '0;
                    a_edge_q <= '0;
                    b_edge_q <= '0;
                    pe_clr_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign a_edge = a_edge_q;
    assign b_edge = b_edge_q;
    assign pe_clr = pe_clr_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl driving a 2x2 output-stationary PE array model.
module tb_systolic_ctrl;

    localparam int N    = 2;
    localparam int KMAX = 8;
    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int KLW  = 4;

    logic            clk;
    logic            rst;
    logic            a_wr_en, b_wr_en;
    logic [AW-1:0]   a_wr_addr, b_wr_addr;
    logic [DW-1:0]   a_wr_data, b_wr_data;
    logic            start;
    logic [KLW-1:0]  k_len;
    logic            acc;
    logic [N*DW-1:0] a_edge, b_edge;
    logic            pe_clr, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    int nz_cnt = 0;

    systolic_ctrl #(.N(N), .KMAX(KMAX), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_wr_en   (a_wr_en),
        .a_wr_addr (a_wr_addr),
        .a_wr_data (a_wr_data),
        .b_wr_en   (b_wr_en),
        .b_wr_addr (b_wr_addr),
        .b_wr_data (b_wr_data),
        .start     (start),
        .k_len     (k_len),
        .acc       (acc),
        .a_edge    (a_edge),
        .b_edge    (b_edge),
        .pe_clr    (pe_clr),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 2x2 PE array: a flows right, b flows down, products accumulate in place
    logic signed [DW-1:0] ai [2][2];
    logic signed [DW-1:0] bi [2][2];
    logic signed [DW-1:0] pa [2][2];
    logic signed [DW-1:0] pb [2][2];
    logic signed [31:0]   pc [2][2];

    assign ai[0][0] = a_edge[0 +: DW];
    assign ai[1][0] = a_edge[DW +: DW];
    assign ai[0][1] = pa[0][0];
    assign ai[1][1] = pa[1][0];
    assign bi[0][0] = b_edge[0 +: DW];
    assign bi[0][1] = b_edge[DW +: DW];
    assign bi[1][0] = pb[0][0];
    assign bi[1][1] = pb[0][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    pa[i][j] <= '0;
                    pb[i][j] <= '0;
                    pc[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    pa[i][j] <= ai[i][j];
                    pb[i][j] <= bi[i][j];
                    pc[i][j] <= pe_clr ? 32'sd0 : pc[i][j] + ai[i][j] * bi[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_edge != '0 || b_edge != '0) nz_cnt <= nz_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_c(input string tag, input int c00, input int c01, input int c10, input int c11);
        check({tag, " C00"}, pc[0][0], c00);
        check({tag, " C01"}, pc[0][1], c01);
        check({tag, " C10"}, pc[1][0], c10);
        check({tag, " C11"}, pc[1][1], c11);
    endtask

    // Writes A[i][k] and B[k][j] (with j == i) in the same cycle
    task automatic wr_ab(input int i, input int k, input int av, input int bv);
        a_wr_en = 1'b1; a_wr_addr = AW'(i * KMAX + k); a_wr_data = DW'(av);
        b_wr_en = 1'b1; b_wr_addr = AW'(i * KMAX + k); b_wr_data = DW'(bv);
        tick();
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    // A = [[a00,a01],[a10,a11]], B = [[b00,b01],[b10,b11]]
    task automatic load2(input int a00, input int a01, input int a10, input int a11,
                         input int b00, input int b01, input int b10, input int b11);
        wr_ab(0, 0, a00, b00);
        wr_ab(0, 1, a01, b10);
        wr_ab(1, 0, a10, b01);
        wr_ab(1, 1, a11, b11);
    endtask

    // Start from an IDLE cycle; cyc = cycle index of done (start sampled at edge 0)
    task automatic run_tile(input int kl, input logic accv, output int cyc);
        tick();
        k_len = KLW'(kl);
        acc   = accv;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("done_timeout", done, 1);
    endtask

    int  cyc;
    int  nz0;
    logic done_seen;

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0; acc = 1'b0;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        tick();
        tick();
        check("rst a_edge", a_edge, 0);
        check("rst b_edge", b_edge, 0);
        check("rst pe_clr", pe_clr, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        rst = 1'b0;
        tick();

        // Basic tile, cycle by cycle
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        k_len = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("c1 pe_clr", pe_clr, 1);
        check("c1 busy", busy, 1);
        check("c1 a_edge", a_edge, 0);
        tick();
        check("c2 pe_clr", pe_clr, 0);
        check("c2 a_edge", a_edge, 16'h0001);
        check("c2 b_edge", b_edge, 16'h0005);
        tick();
        check("c3 a_edge", a_edge, 16'h0302);
        check("c3 b_edge", b_edge, 16'h0607);
        tick();
        check("c4 a_edge", a_edge, 16'h0400);
        check("c4 b_edge", b_edge, 16'h0800);
        tick();
        check("c5 a_edge", a_edge, 0);
        check("c5 b_edge", b_edge, 0);
        check("c5 done", done, 0);
        tick();
        check("c6 done", done, 1);
        check("c6 busy", busy, 1);
        check_c("basic", 19, 22, 43, 50);
        tick();
        check("c7 done", done, 0);
        check("c7 busy", busy, 0);

        // Signed extremes
        load2(-128, -128, 127, -1, -128, 1, -128, 1);
        run_tile(2, 1'b0, cyc);
        check("signed cycles", cyc, 6);
        check_c("signed", 32768, -256, -16128, 126);

        // Empty inner dimension
        nz0 = nz_cnt;
        run_tile(0, 1'b0, cyc);
        check("kl0 cycles", cyc, 2);
        check("kl0 edges quiet", nz_cnt - nz0, 0);
        check_c("kl0", 0, 0, 0, 0);

        // k_len above KMAX clamps; a start while busy is ignored
        for (int k = 0; k < KMAX; k++) begin
            wr_ab(0, k, 1, 1);
            wr_ab(1, k, k + 1, 2);
        end
        tick();
        k_len = 4'd11; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 3;
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("clamp cycles", cyc, 12);
        check_c("clamp", 8, 16, 36, 72);
        done_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            done_seen = done_seen | done;
        end
        check("no second done", done_seen, 0);
        check("idle after clamp", busy, 0);

        // Reset during FEED step 1
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        k_len = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre-rst a_edge", a_edge, 16'h0302);
        #1 rst = 1'b1;
        #1;
        check("mid-rst a_edge", a_edge, 0);
        check("mid-rst b_edge", b_edge, 0);
        check("mid-rst pe_clr", pe_clr, 0);
        check("mid-rst busy", busy, 0);
        check("mid-rst done", done, 0);
        tick();
        rst = 1'b0;
        run_tile(2, 1'b0, cyc);
        check("post-rst cycles", cyc, 6);
        check_c("post-rst", 19, 22, 43, 50);

        // Accumulate mode
`ifdef SYSTOLIC_ACC_EN
        run_tile(2, 1'b1, cyc);
        check("acc cycles", cyc, 5);
        check_c("acc", 38, 44, 86, 100);
`else
        run_tile(2, 1'b1, cyc);
        check("acc ignored cycles", cyc, 6);
        check_c("acc ignored", 19, 22, 43, 50);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for an N×N output-stationary systolic MAC array built from 8-bit signed PEs. It holds operand tiles A (N×K) and B (K×N) in local buffers. On start it clears the PE accumulators, then drives skewed, zero-padded operand streams onto the array's left edge (rows) and top edge (columns). It signals done once every PE accumulator holds its final C[i][j] = Σk A[i][k]·B[k][j].

## Interface
Parameters:
- N, default 2: array dimension (rows = columns).
- KMAX, default 8: maximum inner dimension.
- DW, default 8: operand width, signed.
- AW, default $clog2(N*KMAX): buffer address width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-high reset.
- a_wr_en, in, 1: write A buffer.
- a_wr_addr, in, AW: A address = i*KMAX + k.
- a_wr_data, in, DW: A[i][k].
- b_wr_en, in, 1: write B buffer.
- b_wr_addr, in, AW: B address = j*KMAX + k.
- b_wr_data, in, DW: B[k][j].
- start, in, 1: begin a tile; sampled only in IDLE.
- k_len, in, $clog2(KMAX+1): inner dimension, sampled with start.
- acc, in, 1: keep accumulators. Used only when SYSTOLIC_ACC_EN is defined.
- a_edge, out, N*DW: row i operand in bits [i*DW +: DW], to PE(i,0).a_in.
- b_edge, out, N*DW: column j operand, to PE(0,j).b_in.
- pe_clr, out, 1: accumulator clear, ORed into the PE reset.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse; PE results are final and stable.

## Operation
- States: IDLE → CLEAR → FEED → DONE → IDLE.
- IDLE:
  - start=1 latches kl = min(k_len, KMAX) and moves to CLEAR.
  - start in any other state is ignored.
- CLEAR:
  - One cycle with pe_clr=1 and edges at 0.
  - Next state is FEED if kl>0; otherwise DONE.
- FEED:
  - Counter t runs 0..kl+2N−3, so the state lasts kl+2N−2 cycles.
  - During step t, a_edge row i = A[i][t−i] if 0 ≤ t−i < kl, else 0.
  - During step t, b_edge column j = B[t−j][j] if 0 ≤ t−j < kl, else 0.
- DONE: done=1 for one cycle, edges 0, then IDLE.
- Buffer writes are accepted in all states. Writes during FEED are not prohibited, but the tile result is then undefined.
- Edges and pe_clr are registered outputs with no combinational path from inputs.
- Buffers are not reset.

## Timing
- Reset values: a_edge=0, b_edge=0, pe_clr=0, busy=0, done=0, state IDLE, t=0.
- With start sampled at edge 0:
  - pe_clr is high in cycle 1.
  - FEED step t is present in cycle 2+t.
  - done is high in cycle kl+2N. For N=2, kl=2, that is cycle 6.
- Correctness argument: PE(i,j) sees A[i][k] and B[k][j] together in cycle 2+i+j+k. The last product lands at the end of step kl+2N−3, one cycle before done.
- kl=0: done arrives in cycle 2, and C is all zeros.
- k_len > KMAX is clamped to KMAX.
- The cycle after done is IDLE, so start may be accepted there for back-to-back tiles.
- rst mid-operation: immediately IDLE with all outputs zero. No done pulse for the aborted tile.

## Configuration
- SYSTOLIC_ACC_EN defined: if acc=1 at start, CLEAR is skipped. pe_clr stays 0 and FEED begins in cycle 1, so done comes in cycle kl+2N−1. C then accumulates across tiles.
- SYSTOLIC_ACC_EN undefined: the acc port is present but ignored, and every tile passes through CLEAR.

## Structure
- Package systolic_pkg:
  - State enum (IDLE, CLEAR, FEED, DONE).
  - Default N, KMAX, DW constants.
  - Function for the skewed index test.
- Sub-module systolic_opbuf: N×KMAX register file with one write port and N combinational read ports, instantiated once for A and once for B. The buffer is the natural split.
- FSM and skew logic stay in systolic_ctrl.

## Test plan
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], kl=2, start → pe_clr in cycle 1, done in cycle 6, PE C = [[19,22],[43,50]].
- Signed case: A=[[−128,−128],[127,−1]], B=[[−128,1],[−128,1]], kl=2 → C = [[32768,−256],[−16128,126]], no overflow in 18 bits.
- kl=0 → done in cycle 2, edges never nonzero, C=0.
- k_len=KMAX+3 → behaves exactly as KMAX. start while busy is ignored, with no second done.
- Assert rst during FEED step 1 → all outputs 0 that cycle. A new start afterwards yields correct C.
- With SYSTOLIC_ACC_EN: identical tile run twice, the second with acc=1 → C doubles ([[38,44],[86,100]]) and the second done comes one cycle earlier.
